// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and baud divider helper.
// Used by uart_rx and the future uart_tx.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    // System clocks per line bit, integer truncation.
    function automatic int clks_per_bit(input int clock_mhz, input int baud);
        return (clock_mhz * 1_000_000) / baud;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs.
// Ports: clk, rst_n (async low), d (async in), q (synchronised out).
module sync_2ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1, 3-tap majority at bit centres, one-entry holding reg.
// Ports: clk, rst_n, rx (async line), rx_data/rx_valid/rx_ready handshake,
//        frame_err/overrun sticky flags, err_clr clears both flags.
module uart_rx
    import uart_pkg::*;
#(
    parameter int Clock = 50,
    parameter int Baud  = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    input  logic       err_clr
);

    localparam int CLKS = clks_per_bit(Clock, Baud);
    localparam int HALF = CLKS / 2;
    localparam int CW   = $clog2(CLKS);

    // START decides on the HALF+1 tap; DATA/STOP restart the counter
    // after each decision, so their centre taps end at CLKS-1.
    localparam logic [CW-1:0] START_DEC = CW'(HALF + 1);
    localparam logic [CW-1:0] BIT_DEC   = CW'(CLKS - 1);

    logic rxs;

    uart_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [1:0]    hist_q, hist_d;
    logic          prev_q, prev_d;
    logic [1:0]    live_q, live_d;
    logic          armed_q, armed_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;

    logic maj;
    logic fall;

    sync_2ff #(
        .WIDTH   (1),
        .RST_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rxs)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            hist_q  <= 2'b11;
            prev_q  <= 1'b1;
            live_q  <= '0;
            armed_q <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            hist_q  <= hist_d;
            prev_q  <= prev_d;
            live_q  <= live_d;
            armed_q <= armed_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = ferr_q;
        ovr_d   = ovr_q;

        hist_d = {hist_q[0], rxs};
        prev_d = rxs;
        // The synchroniser shows its reset value for two cycles after
        // release; only arm start detection once a real high is seen,
        // so a line held low across reset is not taken as a start bit.
        live_d  = {live_q[0], 1'b1};
        armed_d = armed_q | (live_q[1] & rxs);

        maj  = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxs) | (hist_q[0] & rxs);
        fall = armed_q & prev_q & ~rxs;

        if (err_clr) begin
            ferr_d = 1'b0;
            ovr_d  = 1'b0;
        end
        if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (fall) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == START_DEC) begin
                    cnt_d   = '0;
                    state_d = maj ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (cnt_q == BIT_DEC) begin
                    cnt_d   = '0;
                    shift_d = {maj, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (cnt_q == BIT_DEC) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (!maj) begin
                        ferr_d = 1'b1;
                    end
                    if (!valid_q || rx_ready) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 50 MHz / 115200 baud (434 clk/bit).
// Frames are driven on negedges; outputs are sampled after negedges.
module tb_uart_rx;

    localparam int CPB = 434;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;

    uart_rx #(
        .Clock (50),
        .Baud  (115200)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .err_clr   (err_clr)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] acc_q[$];
    int         acc_cyc[$];
    int         start_cyc[$];

    // Record every accepted byte (valid && ready) with its cycle.
    always begin
        @(negedge clk);
        #1;
        if (rx_valid && rx_ready) begin
            acc_q.push_back(rx_data);
            acc_cyc.push_back(cyc);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_acc();
        acc_q.delete();
        acc_cyc.delete();
        start_cyc.delete();
    endtask

    function automatic logic [31:0] acc_at(input int i);
        return (acc_q.size() > i) ? 32'(acc_q[i]) : 32'hdead_beef;
    endfunction

    function automatic logic [31:0] lat_ok(input int i);
        int lat;
        if (acc_cyc.size() <= i || start_cyc.size() <= i) return 32'd0;
        lat = acc_cyc[i] - start_cyc[i];
        return 32'(lat >= 4122 && lat <= 4132);
    endfunction

    // 8N1 frame; spike[k] flips data bit k for one clock near its centre
    // (bits 2/4/6 hit offsets 217/218/219, one per majority tap).
    task automatic send_frame(input logic [7:0] b, input logic stop,
                              input logic [7:0] spike);
        logic [9:0] bits;
        int         off;
        bits = {stop, b, 1'b0};
        start_cyc.push_back(cyc);
        for (int i = 0; i < 10; i++) begin
            off = 216 + (i - 1) / 2;
            for (int j = 0; j < CPB; j++) begin
                if (i >= 1 && i <= 8 && spike[i-1] && j == off)
                    rx = ~bits[i];
                else
                    rx = bits[i];
                @(negedge clk);
            end
        end
        rx = 1'b1;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        idle(2);
    endtask

    initial begin
        idle(3);
        check_eq("rst_data", 32'(rx_data), 32'h00);
        check_eq("rst_valid", 32'(rx_valid), 32'd0);
        check_eq("rst_ferr", 32'(frame_err), 32'd0);
        check_eq("rst_ovr", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        idle(10);

        // back-to-back with consumer always ready
        rx_ready = 1'b1;
        clear_acc();
        send_frame(8'h55, 1'b1, 8'h00);
        send_frame(8'hA3, 1'b1, 8'h00);
        idle(50);
        check_eq("basic_count", 32'(acc_q.size()), 32'd2);
        check_eq("basic_b0", acc_at(0), 32'h55);
        check_eq("basic_b1", acc_at(1), 32'hA3);
        check_eq("basic_lat0", lat_ok(0), 32'd1);
        check_eq("basic_lat1", lat_ok(1), 32'd1);
        check_eq("basic_valid", 32'(rx_valid), 32'd0);
        check_eq("basic_ferr", 32'(frame_err), 32'd0);
        check_eq("basic_ovr", 32'(overrun), 32'd0);

        // backpressure and overrun
        rx_ready = 1'b0;
        clear_acc();
        send_frame(8'h12, 1'b1, 8'h00);
        idle(5);
        check_eq("bp_valid0", 32'(rx_valid), 32'd1);
        check_eq("bp_data0", 32'(rx_data), 32'h12);
        check_eq("bp_ovr0", 32'(overrun), 32'd0);
        send_frame(8'h34, 1'b1, 8'h00);
        idle(5);
        check_eq("bp_ovr1", 32'(overrun), 32'd1);
        check_eq("bp_data1", 32'(rx_data), 32'h12);
        check_eq("bp_valid1", 32'(rx_valid), 32'd1);
        rx_ready = 1'b1;
        idle(1);
        rx_ready = 1'b0;
        idle(2);
        check_eq("bp_count", 32'(acc_q.size()), 32'd1);
        check_eq("bp_acc", acc_at(0), 32'h12);
        check_eq("bp_valid2", 32'(rx_valid), 32'd0);
        pulse_clr();
        check_eq("bp_ovr_clr", 32'(overrun), 32'd0);

        // framing error, byte still delivered
        send_frame(8'hFF, 1'b0, 8'h00);
        idle(5);
        check_eq("fe_data", 32'(rx_data), 32'hFF);
        check_eq("fe_valid", 32'(rx_valid), 32'd1);
        check_eq("fe_flag", 32'(frame_err), 32'd1);
        pulse_clr();
        check_eq("fe_clr", 32'(frame_err), 32'd0);
        check_eq("fe_valid_kept", 32'(rx_valid), 32'd1);

        // reset mid bit 3, released early in bit 7 with the line low
        clear_acc();
        fork
            send_frame(8'h55, 1'b1, 8'h00);
            begin
                idle(CPB * 4 + 217);
                rst_n = 1'b0;
                #1;
                check_eq("mrst_data", 32'(rx_data), 32'h00);
                check_eq("mrst_valid", 32'(rx_valid), 32'd0);
                check_eq("mrst_ferr", 32'(frame_err), 32'd0);
                check_eq("mrst_ovr", 32'(overrun), 32'd0);
                idle(CPB * 4 - 207);
                rst_n = 1'b1;
                rx_ready = 1'b1;
            end
        join
        idle(4400);
        check_eq("mrst_nobyte", 32'(acc_q.size()), 32'd0);
        check_eq("mrst_novalid", 32'(rx_valid), 32'd0);
        clear_acc();
        send_frame(8'hA3, 1'b1, 8'h00);
        idle(5);
        check_eq("mrst_next", acc_at(0), 32'hA3);
        check_eq("mrst_data2", 32'(rx_data), 32'hA3);

        // short low glitch, then spikes at 0x00 bit centres
        clear_acc();
        rx = 1'b0;
        idle(100);
        rx = 1'b1;
        idle(600);
        check_eq("gl_nobyte", 32'(acc_q.size()), 32'd0);
        check_eq("gl_valid", 32'(rx_valid), 32'd0);
        send_frame(8'h00, 1'b1, 8'h54);
        idle(5);
        check_eq("sp_count", 32'(acc_q.size()), 32'd1);
        check_eq("sp_byte", acc_at(0), 32'h00);
        check_eq("sp_ferr", 32'(frame_err), 32'd0);

        // byte completes in the same cycle the old one is accepted
        rx_ready = 1'b0;
        send_frame(8'h5A, 1'b1, 8'h00);
        idle(5);
        check_eq("sim_valid0", 32'(rx_valid), 32'd1);
        check_eq("sim_data0", 32'(rx_data), 32'h5A);
        clear_acc();
        fork
            send_frame(8'hC3, 1'b1, 8'h00);
            begin
                idle(4127);
                rx_ready = 1'b1;
                idle(1);
                rx_ready = 1'b0;
            end
        join
        idle(5);
        check_eq("sim_valid1", 32'(rx_valid), 32'd1);
        check_eq("sim_data1", 32'(rx_data), 32'hC3);
        check_eq("sim_ovr1", 32'(overrun), 32'd0);
        check_eq("sim_acc", acc_at(0), 32'h5A);
        check_eq("sim_count", 32'(acc_q.size()), 32'd1);

        // overrun in the same cycle as err_clr: set wins
        fork
            send_frame(8'h77, 1'b1, 8'h00);
            begin
                idle(4127);
                err_clr = 1'b1;
                idle(1);
                err_clr = 1'b0;
            end
        join
        idle(5);
        check_eq("sim_ovr2", 32'(overrun), 32'd1);
        check_eq("sim_data2", 32'(rx_data), 32'hC3);
        pulse_clr();
        check_eq("sim_ovr_clr", 32'(overrun), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver that turns the board RX pin into bytes for the priRV32 core, using the same `Clock` (MHz) and `Baud` parameters as the top level. It synchronises the pin, finds the start bit and samples each bit at its centre with a 3-tap majority vote. Each byte goes into a one-entry holding register behind a valid/ready handshake, with framing-error and overrun status. It sits between the top-level `rx` pin and the core's UART/MMIO consumer.

## Interface
- `Clock`, default 50: system clock frequency in MHz.
- `Baud`, default 115200: line rate in bit/s.
- `clk`, in, 1: system clock; all state updates on its rising edge.
- `rst_n`, in, 1: reset. Asynchronous, active-low.
- `rx`, in, 1: raw serial line. Idles high. Asynchronous to `clk`.
- `rx_data`, out, 8: received byte. LSB is received first.
- `rx_valid`, out, 1: `rx_data` holds an unconsumed byte.
- `rx_ready`, in, 1: consumer accepts the byte.
- `frame_err`, out, 1: sticky flag. Set when the stop bit is sampled low.
- `overrun`, out, 1: sticky flag. Set when a byte completes while `rx_valid` is still high.
- `err_clr`, in, 1: clears `frame_err` and `overrun`.

## Operation
- Divider: `CLKS_PER_BIT = Clock*1_000_000/Baud`, using integer truncation (434 at the defaults). `HALF = CLKS_PER_BIT/2` (217).
- Cycle counter: `$clog2(CLKS_PER_BIT)` bits wide.
- Synchroniser: 2-flop chain on `rx`, reset value 1. All logic uses the synchronised value `rxs`.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - Cycle counter held at 0.
  - A falling edge of `rxs` (previous 1, current 0) moves to START.
- START:
  - Count to `HALF-1`, then take the majority of `rxs` at counts HALF-1, HALF and HALF+1.
  - Majority 0: counter restarts and the FSM enters DATA.
  - Majority 1: glitch. Return to IDLE with no flags touched.
- DATA:
  - Each bit is sampled by the same majority window, one `CLKS_PER_BIT` after the previous centre.
  - Bits are shifted in LSB-first into an 8-bit shift register.
  - The 3-bit index goes 0 to 7; after bit 7 the FSM enters STOP.
- STOP:
  - The stop bit is sampled by majority at its centre.
  - Stop bit 1: byte is good.
  - Stop bit 0: `frame_err` is set and the byte is still delivered.
  - In both cases the FSM returns to IDLE immediately after the centre sample, without waiting for the end of the stop bit. This allows back-to-back frames.
- Delivery, on the stop-centre cycle:
  - If `rx_valid` is 0, or `rx_valid` and `rx_ready` are both 1 in that cycle: load `rx_data` and set `rx_valid`.
  - Otherwise: set `overrun`, keep the old `rx_data`, drop the new byte.
- Handshake: `rx_valid` clears on `rx_valid && rx_ready` unless a new byte loads in the same cycle; a new load wins and `rx_valid` stays 1. `rx_data` is stable while `rx_valid` is 1 and not accepted.
- Error flags:
  - `err_clr` clears both flags.
  - If a set event and `err_clr` happen in the same cycle, the set wins.
- Reset, including mid-frame:
  - State IDLE, counters 0, shift register 0.
  - `rx_data` is 0x00; `rx_valid`, `frame_err` and `overrun` are 0.
  - A partial frame is discarded.
  - After release the receiver waits for a fresh falling edge. A line already low at release is not treated as a start bit until it goes high and falls again.

## Timing
- Edge detection: 2 cycles of synchroniser delay plus 1 cycle of edge detection after the `rx` transition.
- Latency: `rx_valid` rises on the cycle after the stop-bit centre majority. That is about 9.5 bit times (≈4125 clocks at the defaults, ±3 cycles) after the start-bit falling edge.
- Sample spacing: the majority taps are consecutive clocks. The decision registers one cycle after the HALF+1 tap.
- Throughput: one byte per 10 bit times. The consumer must accept within about 1 frame time, or an overrun occurs.
- All outputs are registered. There is no combinational path from `rx` or `rx_ready` to any output.

## Structure
- Shared package `uart_pkg`:
  - `typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t`.
  - Function `clks_per_bit(Clock, Baud)`, also reused by the future `uart_tx`.
- Sub-module `sync_2ff`: parameterised-width two-flop synchroniser with a reset value parameter. The FSM, counters and holding register stay in `uart_rx`.
- The top level instantiates `uart_rx` with its own `Clock` and `Baud`.

## Test plan
- Reset mid-frame: send 0x55 at 115200 with 434 clk/bit and assert `rst_n` low during bit 3. Required: all outputs 0 immediately (asynchronous). After release, the remaining bits produce no byte. A following 0xA3 frame yields `rx_data`=0xA3.
- Basic receive: send 0x55 then 0xA3 back-to-back with `rx_ready`=1 held. Required:
  - Two single-cycle `rx_valid` pulses carrying 0x55 and 0xA3.
  - Each pulse about 4125 clocks after its start edge.
  - No flags set.
- Backpressure: send 0x12 with `rx_ready`=0, then 0x34. Required:
  - `rx_data` stays 0x12 and `rx_valid` stays 1.
  - `overrun`=1 when 0x34 completes.
  - Raising `rx_ready` then consumes 0x12 only.
- Framing error: send 0xFF with the stop bit driven 0. Required: `rx_data`=0xFF, `rx_valid`=1, `frame_err`=1. Pulsing `err_clr` returns `frame_err` to 0.
- Glitch rejection: a 100-clock low pulse on `rx`. Required: return to IDLE and no `rx_valid`. A single-cycle low spike at a bit centre of 0x00 does not flip the bit (majority).
- Simultaneous events: a byte completes in the same cycle as `rx_ready`. Required: `rx_valid` stays 1 with the new data and `overrun` stays 0. An overrun in the same cycle as `err_clr` leaves `overrun`=1.
